multichan_decimator: RTL and testbench

Parametrised successor to the single-stream ÷4 decimator between mic capture and SNR/BPM analysis. It accepts a time-multiplexed multi-channel sample stream tagged with a channel index and keeps independent decimation state per channel. Each channel is decimated by 2^LOG2_R, either by block averaging or by plain subsampling. Results are queued in an output FIFO with valid/ready handshake and overflow accounting.

---
 rtl/multichan_decimator.sv | 157 +++++++++++++++
 tb/tb_multichan_decimator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multichan_decimator.sv
// multichan_decimator
//   Decimates a time-multiplexed, channel-tagged sample stream by R = 2^LOG2_R,
//   keeping independent block state per channel. Each block yields either the
//   floor average of its R samples (mode=1) or its first sample (mode=0). Results
//   are queued in a show-ahead FIFO with valid/ready output and a saturating
//   count of results dropped on a full FIFO.
//
// Ports
//   clk        sample-domain clock (AUD_BCLK at top level)
//   reset      asynchronous active-high reset
//   mode       0 = subsample, 1 = block average (latched at block start)
//   x_valid    input sample valid
//   x_ready    input ready (high whenever reset is low)
//   x_data     signed input sample
//   x_chan     channel index of x_data; indices >= CHANNELS are discarded
//   y_valid    FIFO head valid
//   y_ready    downstream accepts head
//   y_data     signed decimated sample at FIFO head
//   y_chan     channel of y_data
//   level      FIFO occupancy
//   ovf_count  results dropped on full FIFO, saturating
module multichan_decimator #(
    parameter int unsigned W        = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned LOG2_R   = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned OVF_W    = 8,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [W-1:0]     x_data,
    input  logic [CW-1:0]    x_chan,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [W-1:0]     y_data,
    output logic [CW-1:0]    y_chan,
    output logic [LW-1:0]    level,
    output logic [OVF_W-1:0] ovf_count
);

    localparam int unsigned R     = 1 << LOG2_R;
    localparam int unsigned PW    = (LOG2_R > 0) ? LOG2_R : 1;
    localparam int unsigned AccW  = W + LOG2_R;
    // State arrays cover the full x_chan code space so indexing is always in range;
    // slots at or above CHANNELS are never written.
    localparam int unsigned NSlot = 1 << CW;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EW    = W + CW;

    // ---------------- per-channel decimation state ----------------
    logic [PW-1:0]          phase_q [NSlot];
    logic signed [AccW-1:0] acc_q   [NSlot];
    logic [NSlot-1:0]       mode_lat_q;

    logic                   accept, in_range, blk_start, blk_done, eff_mode;
    logic [PW-1:0]          phase_cur, phase_nxt;
    logic signed [AccW-1:0] x_ext, sum_base, sum, sum_sh;
    logic [W-1:0]           result;

    assign x_ready  = ~reset;
    assign in_range = (32'(x_chan) < CHANNELS);
    assign accept   = x_valid & x_ready & in_range;

    always_comb begin
        phase_cur = phase_q[x_chan];
        blk_start = (phase_cur == '0);
        blk_done  = (phase_cur == PW'(R - 1));
        phase_nxt = blk_done ? '0 : phase_cur + PW'(1);
        // At block start the live mode applies; this also makes R=1 pass samples through.
        eff_mode  = blk_start ? mode : mode_lat_q[x_chan];
        x_ext     = AccW'($signed(x_data));
        sum_base  = blk_start ? '0 : acc_q[x_chan];
        sum       = sum_base + x_ext;
        sum_sh    = sum >>> LOG2_R;
        if (eff_mode) begin
            result = sum_sh[W-1:0];
        end else if (blk_start) begin
            result = x_data;
        end else begin
            result = acc_q[x_chan][W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NSlot); i++) begin
                phase_q[i] <= '0;
                acc_q[i]   <= '0;
            end
            mode_lat_q <= '0;
        end else if (accept) begin
            phase_q[x_chan] <= phase_nxt;
            if (blk_start) begin
                mode_lat_q[x_chan] <= mode;
                acc_q[x_chan]      <= x_ext;
            end else if (mode_lat_q[x_chan]) begin
                acc_q[x_chan] <= sum;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [OVF_W-1:0] ovf_q;
    logic             push_req, pop, full, push, drop;
    logic [EW-1:0]    head;

    assign push_req = accept & blk_done;
    assign pop      = y_valid & y_ready;
    assign full     = (level_q == LW'(DEPTH));
    // A concurrent pop frees the slot, so a push on full still lands.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {result, x_chan};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign y_valid   = (level_q != '0);
    assign y_data    = y_valid ? head[EW-1:CW] : '0;
    assign y_chan    = y_valid ? head[CW-1:0] : '0;
    assign level     = level_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_multichan_decimator.sv
module tb_multichan_decimator;

    localparam int W     = 16;
    localparam int CH    = 3;
    localparam int CW    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int OVF_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mode = 1'b0;
    logic             x_valid = 1'b0;
    logic             x_ready;
    logic [W-1:0]     x_data = '0;
    logic [CW-1:0]    x_chan = '0;
    logic             y_valid;
    logic             y_ready = 1'b0;
    logic [W-1:0]     y_data;
    logic [CW-1:0]    y_chan;
    logic [LW-1:0]    level;
    logic [OVF_W-1:0] ovf_count;

    multichan_decimator #(
        .W(W), .CHANNELS(CH), .LOG2_R(2), .DEPTH(DEPTH), .OVF_W(OVF_W)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_chan(x_chan),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_chan(y_chan),
        .level(level), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input int d, input int c);
        exp_t e;
        e.d = W'(d);
        e.c = CW'(c);
        sb.push_back(e);
    endtask

    // Drives one accepted sample; returns 1 time unit after the sampling edge.
    task automatic send(input int c, input int d, input bit m);
        x_chan  = CW'(c);
        x_data  = W'(d);
        mode    = m;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (level != 0 || sb.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check(name, int'(level), 0);
    endtask

    // Scoreboard monitor: every handshake pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (y_valid && y_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got data=%0d chan=%0d, required no output",
                         $signed(y_data), y_chan);
            end else begin
                mon_e = sb.pop_front();
                if (y_data !== mon_e.d || y_chan !== mon_e.c) begin
                    n_fail++;
                    $display("FAIL out_order: got data=%0d chan=%0d, required data=%0d chan=%0d",
                             $signed(y_data), y_chan, $signed(mon_e.d), mon_e.c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_x_ready", int'(x_ready), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(ovf_count), 0);
        check("rst_y_data", int'(y_data), 0);
        reset = 1'b0;
        #1;
        check("run_x_ready", int'(x_ready), 1);
        @(posedge clk);
        #1;
        y_ready = 1'b1;

        // Average ch0: 10,20,30,41 -> 101 >>> 2 = 25
        sb_push(25, 0);
        send(0, 10, 1'b1);
        send(0, 20, 1'b1);
        send(0, 30, 1'b1);
        check("avg_no_early_valid", int'(y_valid), 0);
        send(0, 41, 1'b1);
        check("avg_valid", int'(y_valid), 1);
        check("avg_level", int'(level), 1);
        check("avg_data", int'($signed(y_data)), 25);
        check("avg_chan", int'(y_chan), 0);

        // Negative average ch1: sum -7 >>> 2 = -2 (floor)
        sb_push(-2, 1);
        send(1, -1, 1'b1);
        send(1, -2, 1'b1);
        send(1, -2, 1'b1);
        send(1, -2, 1'b1);
        check("neg_data", int'($signed(y_data)), -2);
        check("neg_chan", int'(y_chan), 1);

        // Subsample, then mode toggled mid-block, then averaged block
        sb_push(5, 0);
        sb_push(1, 0);
        sb_push(6, 0);
        send(0, 5, 1'b0);
        send(0, 6, 1'b0);
        send(0, 7, 1'b0);
        send(0, 8, 1'b0);
        check("sub_data", int'($signed(y_data)), 5);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b1);
        send(0, 4, 1'b1);
        check("toggle_held_sub", int'($signed(y_data)), 1);
        send(0, 4, 1'b1);
        send(0, 4, 1'b1);
        send(0, 8, 1'b1);
        send(0, 8, 1'b1);
        check("toggle_next_avg", int'($signed(y_data)), 6);

        // Interleaved channels with out-of-range channel injected
        sb_push(100, 0);
        sb_push(-100, 1);
        send(0, 100, 1'b1);
        send(1, -100, 1'b1);
        send(0, 100, 1'b1);
        send(3, 7777, 1'b0);
        send(1, -100, 1'b1);
        send(0, 100, 1'b1);
        send(1, -100, 1'b1);
        send(3, 7777, 1'b1);
        send(0, 100, 1'b1);
        check("ilv_ch0_data", int'($signed(y_data)), 100);
        check("ilv_ch0_chan", int'(y_chan), 0);
        send(1, -100, 1'b1);
        check("ilv_ch1_data", int'($signed(y_data)), -100);
        check("ilv_ch1_chan", int'(y_chan), 1);
        check("ilv_level", int'(level), 1);
        send(3, 1234, 1'b1);
        send(3, 1234, 1'b1);
        check("bad_chan_level", int'(level), 0);
        check("bad_chan_valid", int'(y_valid), 0);

        // Overflow: 6 blocks into a 4-deep FIFO with no drain
        y_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) sb_push(k, 0);
            for (int j = 0; j < 4; j++) send(0, k, 1'b1);
        end
        check("ovf_level", int'(level), 4);
        check("ovf_count", int'(ovf_count), 2);
        check("ovf_head_stable", int'($signed(y_data)), 1);
        // Push on full with concurrent pop is accepted
        sb_push(7, 0);
        send(0, 7, 1'b1);
        send(0, 7, 1'b1);
        send(0, 7, 1'b1);
        y_ready = 1'b1;
        send(0, 7, 1'b1);
        check("fullpop_level", int'(level), 4);
        check("fullpop_ovf", int'(ovf_count), 2);
        check("fullpop_head", int'($signed(y_data)), 2);
        wait_drain("ovf_drain_level");

        // Reset discards queued results and partial blocks
        y_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(1, 9, 1'b1);
        send(0, 50, 1'b1);
        send(0, 50, 1'b1);
        check("pre_rst_level", int'(level), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_x_ready", int'(x_ready), 0);
        check("mid_rst_y_valid", int'(y_valid), 0);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_y_data", int'(y_data), 0);
        check("mid_rst_ovf", int'(ovf_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        y_ready = 1'b1;
        sb_push(8, 0);
        for (int j = 0; j < 4; j++) send(0, 8, 1'b1);
        check("post_rst_data", int'($signed(y_data)), 8);
        wait_drain("post_rst_drain");

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
